word_serializer: RTL and testbench

WORD_SERIALIZER -- requirements
Module: word_serializer

---
 rtl/serializer_pkg.sv | 24 ++
 rtl/mod_counter.sv | 46 ++++
 rtl/word_serializer.sv | 110 +++++++++++
 tb/tb_word_serializer.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serializer_pkg.sv
// -----------------------------------------------------------------------------
// serializer_pkg
// Definitions shared by the word serializer and its matching deserializer:
//   ser_state_e - two-state transfer FSM encoding (IDLE / SHIFT)
//   cnt_width() - bit-counter width for a given word width, ceil(log2(n)),
//                 never less than 1
// -----------------------------------------------------------------------------
package serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,  // no word held
    SHIFT = 1'b1   // word held, bits pending
  } ser_state_e;

  function automatic int cnt_width(input int modulus);
    int w;
    w = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << w) < modulus) w = w + 1;
    end
    return w;
  endfunction

endpackage : serializer_pkg

// File: rtl/mod_counter.sv
// -----------------------------------------------------------------------------
// mod_counter
// Modulo-MODULUS up counter with synchronous load and count enable. The count
// runs 0..MODULUS-1 and wraps to 0, so it never holds a value outside that
// range even when MODULUS is not a power of two.
// Ports:
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset, clears the count
//   i_load       in   load i_load_value this edge (has priority over i_en)
//   i_load_value in   value to load
//   i_en         in   advance the count this edge
//   o_count      out  current count
// -----------------------------------------------------------------------------
module mod_counter
  import serializer_pkg::*;
#(
  parameter int MODULUS = 8,
  parameter int CW      = cnt_width(MODULUS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_load,
  input  logic [CW-1:0] i_load_value,
  input  logic          i_en,
  output logic [CW-1:0] o_count
);

  localparam logic [CW-1:0] MAX_COUNT = CW'(MODULUS - 1);

  logic [CW-1:0] r_count;

  // NOTE: sequential state is written with non-blocking (<=) assignments so
  // every register samples its inputs as they were before the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_value;
    end else if (i_en) begin
      r_count <= (r_count == MAX_COUNT) ? '0 : r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule : mod_counter

// File: rtl/word_serializer.sv
// -----------------------------------------------------------------------------
// word_serializer
// Accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit
// per accepted beat on a valid/ready serial stream, LSB or MSB first. A new
// word can be taken on the same edge the last bit leaves, so consecutive
// words stream without idle cycles.
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_data    in   parallel word to transmit
//   in_valid   in   in_data is valid
//   in_ready   out  a word is accepted this cycle
//   ser_out    out  current serial bit
//   ser_valid  out  ser_out holds a valid bit
//   ser_ready  in   downstream accepts the bit this cycle
//   ser_last   out  current bit is the last bit of the word
//   busy       out  a word is loaded and not yet fully transferred
// -----------------------------------------------------------------------------
module word_serializer
  import serializer_pkg::*;
#(
  parameter int WIDTH     = 8,     // legal range 2..32
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_last,
  output logic             busy
);

  localparam int              CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  ser_state_e       r_state;
  ser_state_e       w_state_next;
  logic [WIDTH-1:0] r_shift;
  logic [CNT_W-1:0] w_count;
  logic             w_shifting;
  logic             w_last;
  logic             w_word_xfer;
  logic             w_bit_xfer;
  logic             w_head;

  assign w_shifting = (r_state == SHIFT);
  assign w_last     = w_shifting && (w_count == LAST_IDX);

  // The only combinational input-to-output path: the slot frees up in the
  // same cycle the final bit is being taken downstream.
  assign in_ready    = !w_shifting || (w_last && ser_ready);
  assign w_word_xfer = in_valid && in_ready;
  assign w_bit_xfer  = w_shifting && ser_ready;

  // Load wins over enable, so a back-to-back capture restarts the count at 0;
  // a plain last-bit transfer wraps it to 0 by itself.
  mod_counter #(
    .MODULUS (WIDTH),
    .CW      (CNT_W)
  ) u_bit_counter (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_load       (w_word_xfer),
    .i_load_value ('0),
    .i_en         (w_bit_xfer),
    .o_count      (w_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:  if (w_word_xfer) w_state_next = SHIFT;
      SHIFT: if (w_bit_xfer && w_last && !w_word_xfer) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // The word is copied into the shift register on capture, so in_data is free
  // to change while the word is in flight.
  // NOTE: the shift register is a plain register (not an array), so it is
  // cleared by reset like the rest of the datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= '0;
    end else if (w_word_xfer) begin
      r_shift <= in_data;
    end else if (w_bit_xfer) begin
      if (MSB_FIRST) r_shift <= {r_shift[WIDTH-2:0], 1'b0};
      else           r_shift <= {1'b0, r_shift[WIDTH-1:1]};
    end
  end

  assign w_head    = MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0];
  assign ser_out   = w_shifting && w_head;
  assign ser_valid = w_shifting;
  assign ser_last  = w_last;
  assign busy      = w_shifting;

endmodule : word_serializer

// File: tb/tb_word_serializer.sv
// -----------------------------------------------------------------------------
// tb_word_serializer
// Three serializers: 8-bit LSB first, 8-bit MSB first, 5-bit LSB first.
// Each accepted word is expanded into its expected bit sequence and queued;
// a monitor on the falling edge compares every presented bit and the
// handshake/status outputs against that queue.
// -----------------------------------------------------------------------------
module tb_word_serializer;

  localparam int NI = 3;

  typedef struct {
    logic b;
    logic last;
  } exp_t;

  logic            clk = 1'b0;
  logic [NI-1:0]   rst_n;
  logic [NI-1:0]   in_valid;
  logic [NI-1:0]   in_ready;
  logic [NI-1:0]   ser_out;
  logic [NI-1:0]   ser_valid;
  logic [NI-1:0]   ser_ready;
  logic [NI-1:0]   ser_last;
  logic [NI-1:0]   busy;
  logic [31:0]     in_data [NI];
  logic [NI-1:0]   rdy_rand;
  logic [NI-1:0]   rdy_dir;
  logic [NI-1:0]   rdy_rnd;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int n_bits [NI];

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  always #5 clk = ~clk;

  assign ser_ready = (rdy_rand & rdy_rnd) | (~rdy_rand & rdy_dir);

  word_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb8 (
    .clk(clk), .rst_n(rst_n[0]), .in_data(in_data[0][7:0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .ser_out(ser_out[0]), .ser_valid(ser_valid[0]),
    .ser_ready(ser_ready[0]), .ser_last(ser_last[0]), .busy(busy[0]));

  word_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb8 (
    .clk(clk), .rst_n(rst_n[1]), .in_data(in_data[1][7:0]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .ser_out(ser_out[1]), .ser_valid(ser_valid[1]),
    .ser_ready(ser_ready[1]), .ser_last(ser_last[1]), .busy(busy[1]));

  word_serializer #(.WIDTH(5), .MSB_FIRST(1'b0)) u_lsb5 (
    .clk(clk), .rst_n(rst_n[2]), .in_data(in_data[2][4:0]), .in_valid(in_valid[2]),
    .in_ready(in_ready[2]), .ser_out(ser_out[2]), .ser_valid(ser_valid[2]),
    .ser_ready(ser_ready[2]), .ser_last(ser_last[2]), .busy(busy[2]));

  function automatic int width_of(input int i);
    return (i == 2) ? 5 : 8;
  endfunction

  function automatic bit msb_of(input int i);
    return (i == 1);
  endfunction

  // ---------------------------------------------------------------- scoreboard
  function automatic int q_size(input int i);
    case (i)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic exp_t q_front(input int i);
    case (i)
      0:       return q0[0];
      1:       return q1[0];
      default: return q2[0];
    endcase
  endfunction

  function automatic void q_pop(input int i);
    case (i)
      0:       void'(q0.pop_front());
      1:       void'(q1.pop_front());
      default: void'(q2.pop_front());
    endcase
  endfunction

  function automatic void q_clear(input int i);
    case (i)
      0:       q0.delete();
      1:       q1.delete();
      default: q2.delete();
    endcase
  endfunction

  function automatic void q_push(input int i, input exp_t e);
    case (i)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endfunction

  // Reference model: k-th bit sent is word bit k (LSB first) or W-1-k.
  function automatic void push_word(input int i, input logic [31:0] d);
    int   w;
    int   idx;
    exp_t e;
    w = width_of(i);
    for (int k = 0; k < w; k++) begin
      idx    = msb_of(i) ? (w - 1 - k) : k;
      e.b    = d[idx];
      e.last = (k == w - 1);
      q_push(i, e);
    end
  endfunction

  task automatic check(input string name, input int i, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d @cyc %0d: got %0h expected %0h", name, i, cyc, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- monitor
  int   mon_sz;
  exp_t mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    rdy_rnd = NI'($urandom);
  end

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (!rst_n[i]) begin
        check("rst_in_ready", i, 32'(in_ready[i]), 32'd1);
        check("rst_ser_valid", i, 32'(ser_valid[i]), 32'd0);
        check("rst_ser_out", i, 32'(ser_out[i]), 32'd0);
        check("rst_ser_last", i, 32'(ser_last[i]), 32'd0);
        check("rst_busy", i, 32'(busy[i]), 32'd0);
        q_clear(i);
      end else begin
        mon_sz = q_size(i);
        check("in_ready", i, 32'(in_ready[i]),
              32'((mon_sz == 0) || (mon_sz == 1 && ser_ready[i])));
        check("ser_valid", i, 32'(ser_valid[i]), 32'(mon_sz != 0));
        check("busy", i, 32'(busy[i]), 32'(mon_sz != 0));
        if (mon_sz == 0) begin
          check("idle_ser_out", i, 32'(ser_out[i]), 32'd0);
          check("idle_ser_last", i, 32'(ser_last[i]), 32'd0);
        end else begin
          mon_e = q_front(i);
          check("ser_out", i, 32'(ser_out[i]), 32'(mon_e.b));
          check("ser_last", i, 32'(ser_last[i]), 32'(mon_e.last));
          if (ser_valid[i] && ser_ready[i]) begin
            q_pop(i);
            n_bits[i]++;
          end
        end
        if (in_valid[i] && in_ready[i]) push_word(i, in_data[i]);
      end
    end
  end

  // ---------------------------------------------------------------- driver
  // Presents a word and returns 1 time unit after the edge that captured it,
  // leaving in_valid high so the caller can chain words back to back.
  task automatic send(input int i, input logic [31:0] d);
    int n;
    n = 0;
    in_data[i]  = d;
    in_valid[i] = 1'b1;
    while (1) begin
      @(negedge clk);
      if (in_ready[i]) break;
      n++;
      if (n > 300) begin
        check("accept_timeout", i, 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int i);
    int n;
    n = 0;
    while (q_size(i) != 0 && n < 600) begin
      @(posedge clk);
      n++;
    end
    check("drain_empty", i, 32'(q_size(i)), 32'd0);
    #1;
  endtask

  int t0;
  int b0;
  logic [31:0] tmp;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = '0;
    in_valid = '0;
    rdy_rand = '0;
    rdy_dir  = '0;
    for (int i = 0; i < NI; i++) begin
      in_data[i] = '0;
      n_bits[i]  = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = '1;
    repeat (2) @(posedge clk);
    #1;

    // 0xA5, LSB first, downstream always ready.
    rdy_dir[0] = 1'b1;
    b0 = n_bits[0];
    send(0, 32'hA5);
    in_valid[0] = 1'b0;
    drain(0);
    check("a5_bit_count", 0, 32'(n_bits[0] - b0), 32'd8);

    // 0x0F then 0xF0 with in_valid held: second capture exactly 8 edges later.
    b0 = n_bits[0];
    send(0, 32'h0F);
    t0 = cyc;
    send(0, 32'hF0);
    check("b2b_spacing", 0, 32'(cyc - t0), 32'd8);
    in_valid[0] = 1'b0;
    drain(0);
    check("b2b_bit_count", 0, 32'(n_bits[0] - b0), 32'd16);

    // 0x81 with a 3-cycle downstream stall while bit 2 is presented.
    b0 = n_bits[0];
    tmp = 32'h81;
    send(0, tmp);
    in_valid[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rdy_dir[0] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("stall_valid", 0, 32'(ser_valid[0]), 32'd1);
      check("stall_out", 0, 32'(ser_out[0]), 32'(tmp[2]));
      check("stall_last", 0, 32'(ser_last[0]), 32'd0);
    end
    @(posedge clk);
    #1;
    rdy_dir[0] = 1'b1;
    drain(0);
    check("stall_bit_count", 0, 32'(n_bits[0] - b0), 32'd8);

    // Reset while bit 4 of 0xFF is presented, then 0x01.
    send(0, 32'hFF);
    in_valid[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n[0] = 1'b1;
    b0 = n_bits[0];
    repeat (3) @(posedge clk);
    #1;
    check("no_bits_after_reset", 0, 32'(n_bits[0] - b0), 32'd0);
    send(0, 32'h01);
    in_valid[0] = 1'b0;
    drain(0);
    check("post_reset_bit_count", 0, 32'(n_bits[0] - b0), 32'd8);

    // MSB first.
    rdy_dir[1] = 1'b1;
    b0 = n_bits[1];
    send(1, 32'hA5);
    send(1, 32'h3C);
    in_valid[1] = 1'b0;
    drain(1);
    check("msb_bit_count", 1, 32'(n_bits[1] - b0), 32'd16);

    // WIDTH=5, 0x1F and 0x00 back to back.
    rdy_dir[2] = 1'b1;
    b0 = n_bits[2];
    send(2, 32'h1F);
    t0 = cyc;
    send(2, 32'h00);
    check("w5_spacing", 2, 32'(cyc - t0), 32'd5);
    in_valid[2] = 1'b0;
    drain(2);
    check("w5_bit_count", 2, 32'(n_bits[2] - b0), 32'd10);

    // Random words, random gaps, random downstream readiness; in_data is
    // scrambled during gaps while a word is still in flight.
    for (int i = 0; i < NI; i++) begin
      rdy_rand[i] = 1'b1;
      repeat (25) begin
        send(i, $urandom);
        if ($urandom_range(0, 1) == 1) begin
          in_valid[i] = 1'b0;
          in_data[i]  = $urandom;
          repeat ($urandom_range(1, 3)) @(posedge clk);
          #1;
        end
      end
      in_valid[i] = 1'b0;
      in_data[i]  = $urandom;
      drain(i);
      rdy_rand[i] = 1'b0;
    end

    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      check("final_queue_empty", i, 32'(q_size(i)), 32'd0);
      check("final_idle", i, 32'(busy[i]), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_word_serializer
